// File: rtl/nonce_arb_pkg.sv
// Shared types and helpers for the nonce result arbiter.
package nonce_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOADED = 1'b1
    } state_t;

    localparam int unsigned STAT_W = 32;

    // Round-robin successor with an explicit wrap, so non-power-of-two counts work.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_grant.sv
// Combinational round-robin picker: one-hot grant to the first set req at or after ptr.
module rr_grant #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant
);

    int unsigned idx;
    logic        found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = 32'(ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && req[idx[IDX_W-1:0]]) begin
                grant[idx[IDX_W-1:0]] = 1'b1;
                found                 = 1'b1;
            end
        end
    end

endmodule

// File: rtl/nonce_result_arbiter.sv
// Round-robin arbiter funnelling found-nonce words from NUM_REQ cores into one output register.
// Optional per-requester grant counters are enabled with NONCE_ARB_STATS_EN.
module nonce_result_arbiter
    import nonce_arb_pkg::*;
#(
    parameter  int unsigned NUM_REQ = 4,
    parameter  int unsigned DATA_W  = 64,
    localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         out_data,
    output logic [IDX_W-1:0]          out_src,
    output logic                      busy
`ifdef NONCE_ARB_STATS_EN
    ,
    input  logic [IDX_W-1:0]          stat_sel,
    input  logic                      stat_clr,
    output logic [STAT_W-1:0]         stat_count
`endif
);

    state_t             state;
    logic [IDX_W-1:0]   rr_ptr;
    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   grant_idx;
    logic [DATA_W-1:0]  win_data;
    logic               can_load;
    logic               xfer;

    rr_grant #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_grant (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (grant)
    );

    // Encode the one-hot grant and mux the winning word.
    always_comb begin
        grant_idx = '0;
        win_data  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                grant_idx = IDX_W'(i);
                win_data  = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Refill allowed when empty or when the held word drains this cycle; never during reset.
    assign can_load  = (state == IDLE) || out_ready;
    assign req_ready = rstn ? (grant & {NUM_REQ{can_load}}) : '0;
    assign xfer      = |req_ready;
    assign out_valid = (state == LOADED);
    assign busy      = out_valid || (|req_valid);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state    <= IDLE;
            out_data <= '0;
            out_src  <= '0;
            rr_ptr   <= '0;
        end else if (xfer) begin
            state    <= LOADED;
            out_data <= win_data;
            out_src  <= grant_idx;
            rr_ptr   <= IDX_W'(rr_next(32'(grant_idx), NUM_REQ));
        end else if ((state == LOADED) && out_ready) begin
            state <= IDLE;
        end
    end

`ifdef NONCE_ARB_STATS_EN
    logic [STAT_W-1:0] stat_cnt [NUM_REQ];

    // Saturating grant counters; clear wins over a same-cycle increment.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                stat_cnt[i] <= '0;
            end
            stat_count <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (stat_clr) begin
                    stat_cnt[i] <= '0;
                end else if (req_ready[i] && req_valid[i] && (stat_cnt[i] != '1)) begin
                    stat_cnt[i] <= stat_cnt[i] + STAT_W'(1);
                end
            end
            stat_count <= (32'(stat_sel) < NUM_REQ) ? stat_cnt[stat_sel] : '0;
        end
    end
`endif

endmodule
